// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/forwarding control for a 5-stage pipeline with memory watchdog.
// Define HAZ_PERF_CNT_EN to add the StallCnt/FlushCnt performance counter outputs.
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 15
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] A1_id,
  input  logic [3:0] A2_id,
  input  logic [3:0] A1_ex,
  input  logic [3:0] A2_ex,
  input  logic [3:0] A3_ex,
  input  logic       RF_WE_ex,
  input  logic       WBSelect_ex,
  input  logic [3:0] A3_mem,
  input  logic       RF_WE_mem,
  input  logic [3:0] A3_wb,
  input  logic       RF_WE_wb,
  input  logic       BranchTaken_ex,
  input  logic       MemReq_mem,
  input  logic       MemReady,
  output logic       Stall_IF,
  output logic       Stall_ID,
  output logic       Stall_EX,
  output logic       Stall_MEM,
  output logic       Flush_ID,
  output logic       Flush_EX,
  output logic [1:0] FwdA_ex,
  output logic [1:0] FwdB_ex,
  output logic       MemErr
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [15:0] StallCnt,
  output logic [15:0] FlushCnt
`endif
);
  typedef enum logic [1:0] {RUN, BR_FLUSH, MEM_WAIT} state_t;
  state_t state, state_n;
  logic [7:0] cnt, cnt_n;
  logic mem_err_q, miss, load_use, tmo, stall_all, br, lu_s;
  assign miss = MemReq_mem && !MemReady;
  assign load_use = RF_WE_ex && WBSelect_ex && A3_ex != 4'd15 && (A3_ex == A1_id || A3_ex == A2_id);
  assign tmo = state == MEM_WAIT && !MemReady && cnt == 8'(MEM_TIMEOUT);
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= RUN;
      cnt       <= 8'd0;
      mem_err_q <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      mem_err_q <= mem_err_q | tmo;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      RUN: begin
        if (miss) begin
          state_n = MEM_WAIT;
          cnt_n   = 8'd1;
        end else if (BranchTaken_ex && FLUSH_CYCLES > 1) begin
          state_n = BR_FLUSH;
          cnt_n   = 8'(FLUSH_CYCLES - 1);
        end
      end
      BR_FLUSH: begin
        if (miss) begin
          state_n = MEM_WAIT;
          cnt_n   = 8'd1;
        end else begin
          cnt_n   = cnt - 8'd1;
          state_n = cnt == 8'd1 ? RUN : BR_FLUSH;
        end
      end
      MEM_WAIT: begin
        state_n = (MemReady || tmo) ? RUN : MEM_WAIT;
        cnt_n   = (MemReady || tmo) ? 8'd0 : cnt + 8'd1;
      end
      default: begin
        state_n = RUN;
        cnt_n   = 8'd0;
      end
    endcase
  end
  // Every hazard output is gated by RST so a reset cycle never leaks a stall or flush.
  always_comb begin
    stall_all = RST && (state == MEM_WAIT ? !MemReady && !tmo : miss);
    br        = RST && state == RUN && !miss && BranchTaken_ex;
    lu_s      = RST && state == RUN && !miss && !BranchTaken_ex && load_use;
    Stall_IF  = stall_all | lu_s;
    Stall_ID  = stall_all | lu_s;
    Stall_EX  = stall_all;
    Stall_MEM = stall_all;
    Flush_ID  = br | (RST && state == BR_FLUSH && !miss);
    Flush_EX  = br | lu_s;
    FwdA_ex   = !RST || A1_ex == 4'd15 ? 2'b00 :
                RF_WE_mem && A3_mem == A1_ex ? 2'b01 :
                RF_WE_wb && A3_wb == A1_ex ? 2'b10 : 2'b00;
    FwdB_ex   = !RST || A2_ex == 4'd15 ? 2'b00 :
                RF_WE_mem && A3_mem == A2_ex ? 2'b01 :
                RF_WE_wb && A3_wb == A2_ex ? 2'b10 : 2'b00;
    MemErr    = mem_err_q | (RST & tmo);
  end
`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge CLK) begin
    if (!RST) begin
      StallCnt <= 16'd0;
      FlushCnt <= 16'd0;
    end else begin
      if ((Stall_IF | Stall_ID | Stall_EX | Stall_MEM) && StallCnt != 16'hFFFF) StallCnt <= StallCnt + 16'd1;
      if (br && FlushCnt != 16'hFFFF) FlushCnt <= FlushCnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: vector table, directed corner sequences and random run against a reference model.
module tb_pipe_hazard_ctrl;
  localparam int FC = 2;
  localparam int TO = 15;
  typedef struct packed {
    logic rst;
    logic [3:0] a1_id, a2_id, a1_ex, a2_ex, a3_ex;
    logic we_ex, wbs_ex;
    logic [3:0] a3_mem;
    logic we_mem;
    logic [3:0] a3_wb;
    logic we_wb, br, req, rdy;
  } vin_t;
  typedef struct {
    vin_t in;
    logic [10:0] exp;
    string name;
  } vec_t;
  localparam logic [10:0] S_ALL  = 11'b11110000000;
  localparam logic [10:0] F_BOTH = 11'b00001100000;
  localparam logic [10:0] F_ID   = 11'b00001000000;
  localparam logic [10:0] LU     = 11'b11000100000;
  localparam logic [10:0] ERR    = 11'b00000000001;
  localparam logic [10:0] NO_ERR = 11'b11111111110;
  logic CLK = 1'b0;
  logic RST;
  logic [3:0] A1_id, A2_id, A1_ex, A2_ex, A3_ex, A3_mem, A3_wb;
  logic RF_WE_ex, WBSelect_ex, RF_WE_mem, RF_WE_wb, BranchTaken_ex, MemReq_mem, MemReady;
  logic Stall_IF, Stall_ID, Stall_EX, Stall_MEM, Flush_ID, Flush_EX, MemErr;
  logic [1:0] FwdA_ex, FwdB_ex;
  logic [10:0] obs;
  int n_cmp = 0;
  int n_err = 0;
  always #5 CLK = ~CLK;
  pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .A1_id(A1_id), .A2_id(A2_id), .A1_ex(A1_ex), .A2_ex(A2_ex),
    .A3_ex(A3_ex), .RF_WE_ex(RF_WE_ex), .WBSelect_ex(WBSelect_ex), .A3_mem(A3_mem),
    .RF_WE_mem(RF_WE_mem), .A3_wb(A3_wb), .RF_WE_wb(RF_WE_wb), .BranchTaken_ex(BranchTaken_ex),
    .MemReq_mem(MemReq_mem), .MemReady(MemReady), .Stall_IF(Stall_IF), .Stall_ID(Stall_ID),
    .Stall_EX(Stall_EX), .Stall_MEM(Stall_MEM), .Flush_ID(Flush_ID), .Flush_EX(Flush_EX),
    .FwdA_ex(FwdA_ex), .FwdB_ex(FwdB_ex), .MemErr(MemErr)
  );
  assign obs = {Stall_IF, Stall_ID, Stall_EX, Stall_MEM, Flush_ID, Flush_EX, FwdA_ex, FwdB_ex, MemErr};
  task automatic apply(input vin_t v);
    RST = v.rst; A1_id = v.a1_id; A2_id = v.a2_id; A1_ex = v.a1_ex; A2_ex = v.a2_ex;
    A3_ex = v.a3_ex; RF_WE_ex = v.we_ex; WBSelect_ex = v.wbs_ex; A3_mem = v.a3_mem;
    RF_WE_mem = v.we_mem; A3_wb = v.a3_wb; RF_WE_wb = v.we_wb; BranchTaken_ex = v.br;
    MemReq_mem = v.req; MemReady = v.rdy;
  endtask
  task automatic check(input string name, input logic [10:0] exp, input logic [10:0] mask);
    n_cmp++;
    if ((obs & mask) !== (exp & mask)) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (IF ID EX MEM FID FEX FA FB ERR)", name, obs & mask, exp & mask);
    end
  endtask
  task automatic cyc(input string name, input logic [10:0] exp, input logic [10:0] mask = 11'h7FF);
    #1 check(name, exp, mask);
    @(posedge CLK);
    #1;
  endtask
  function automatic logic [1:0] fwd_ref(input logic [3:0] a, input vin_t v);
    if (a == 4'd15) return 2'b00;
    if (v.we_mem && v.a3_mem == a) return 2'b01;
    if (v.we_wb && v.a3_wb == a) return 2'b10;
    return 2'b00;
  endfunction
  // Model state: waiting with wn MEM_WAIT cycles elapsed, fl remaining Flush_ID-only cycles, err sticky.
  function automatic logic [10:0] model(input vin_t v, input bit waiting, input int wn, input int fl, input bit err);
    logic [3:0] st;
    logic fid, fex;
    bit lu;
    st = 4'b0; fid = 1'b0; fex = 1'b0;
    if (!v.rst) return {10'b0, err};
    lu = v.we_ex && v.wbs_ex && v.a3_ex != 4'd15 && (v.a3_ex == v.a1_id || v.a3_ex == v.a2_id);
    if (waiting) begin
      if (!v.rdy && wn == TO) err = 1'b1;
      else if (!v.rdy) st = 4'b1111;
    end else if (v.req && !v.rdy) st = 4'b1111;
    else if (fl > 0) fid = 1'b1;
    else if (v.br) begin fid = 1'b1; fex = 1'b1; end
    else if (lu) begin st = 4'b1100; fex = 1'b1; end
    return {st, fid, fex, fwd_ref(v.a1_ex, v), fwd_ref(v.a2_ex, v), err};
  endfunction
  vec_t tbl[14];
  vin_t v;
  bit m_wait, m_err;
  int m_wn, m_fl;
  initial begin
    tbl[0]  = '{'{1,0,0,3,0,0,0,0,3,1,3,1,0,0,0}, 11'b00000001000, "fwdA_mem"};
    tbl[1]  = '{'{1,0,0,3,0,0,0,0,3,0,3,1,0,0,0}, 11'b00000010000, "fwdA_wb"};
    tbl[2]  = '{'{1,0,0,15,0,0,0,0,15,1,15,1,0,0,0}, 11'b00000000000, "fwdA_pc"};
    tbl[3]  = '{'{1,0,0,0,7,0,0,0,7,1,7,1,0,0,0}, 11'b00000000010, "fwdB_mem"};
    tbl[4]  = '{'{1,0,0,0,7,0,0,0,6,1,7,1,0,0,0}, 11'b00000000100, "fwdB_wb"};
    tbl[5]  = '{'{1,0,0,2,9,0,0,0,2,1,9,1,0,0,0}, 11'b00000001100, "fwd_both"};
    tbl[6]  = '{'{1,0,5,0,0,5,1,1,0,0,0,0,0,0,0}, LU, "lu_a2"};
    tbl[7]  = '{'{1,5,0,0,0,5,1,1,0,0,0,0,0,0,0}, LU, "lu_a1"};
    tbl[8]  = '{'{1,5,0,0,0,5,1,0,0,0,0,0,0,0,0}, 11'b0, "lu_noload"};
    tbl[9]  = '{'{1,15,0,0,0,15,1,1,0,0,0,0,0,0,0}, 11'b0, "lu_pc"};
    tbl[10] = '{'{1,5,0,0,0,5,0,1,0,0,0,0,0,0,0}, 11'b0, "lu_nowe"};
    tbl[11] = '{'{1,0,0,0,0,0,0,0,0,0,0,0,0,1,1}, 11'b0, "zero_wait"};
    tbl[12] = '{'{1,0,5,4,0,5,1,1,0,0,4,1,0,0,0}, 11'b11000110000, "lu_fwd"};
    tbl[13] = '{'{1,0,5,0,0,5,1,1,0,0,0,0,0,1,1}, LU, "lu_zero_wait"};
    v = '0;
    apply(v);
    @(posedge CLK);
    #1;
    v.a1_ex = 4'd3; v.a3_mem = 4'd3; v.we_mem = 1'b1;
    apply(v);
    cyc("reset_out", 11'b0, NO_ERR);
    v = '0; v.rst = 1'b1;
    apply(v);
    cyc("idle", 11'b0);
    for (int i = 0; i < 14; i++) begin
      apply(tbl[i].in);
      cyc(tbl[i].name, tbl[i].exp);
    end
    v = '0; v.rst = 1'b1;
    apply(v);
    cyc("lu_released", 11'b0);
    BranchTaken_ex = 1'b1;
    cyc("br0", F_BOTH);
    BranchTaken_ex = 1'b0;
    cyc("br1", F_ID);
    cyc("br2", 11'b0);
    MemReq_mem = 1'b1;
    for (int i = 0; i < 3; i++) cyc("wait3", S_ALL);
    MemReady = 1'b1;
    cyc("wait_ready", 11'b0);
    MemReq_mem = 1'b0;
    cyc("wait_done", 11'b0);
    MemReq_mem = 1'b1; MemReady = 1'b0;
    for (int i = 0; i < TO; i++) cyc("to_stall", S_ALL);
    cyc("timeout", ERR);
    MemReq_mem = 1'b0; MemReady = 1'b1;
    cyc("err_sticky", ERR);
    MemReq_mem = 1'b1; MemReady = 1'b0;
    cyc("w_err0", S_ALL | ERR);
    cyc("w_err1", S_ALL | ERR);
    RST = 1'b0;
    cyc("rst_mid_wait", 11'b0, NO_ERR);
    RST = 1'b1; MemReq_mem = 1'b0; MemReady = 1'b1;
    cyc("post_rst", 11'b0);
    BranchTaken_ex = 1'b1;
    cyc("brr0", F_BOTH);
    RST = 1'b0; BranchTaken_ex = 1'b0;
    cyc("rst_mid_flush", 11'b0, NO_ERR);
    RST = 1'b1;
    cyc("no_residual", 11'b0);
    BranchTaken_ex = 1'b1;
    cyc("brm0", F_BOTH);
    BranchTaken_ex = 1'b0; MemReq_mem = 1'b1; MemReady = 1'b0;
    cyc("br_miss", S_ALL);
    MemReady = 1'b1;
    cyc("br_miss_rdy", 11'b0);
    MemReq_mem = 1'b0;
    cyc("flush_dropped", 11'b0);
    MemReq_mem = 1'b1; MemReady = 1'b0; BranchTaken_ex = 1'b1;
    cyc("miss_beats_br", S_ALL);
    MemReady = 1'b1;
    cyc("br_ignored", 11'b0);
    MemReq_mem = 1'b0;
    cyc("br_reeval", F_BOTH);
    BranchTaken_ex = 1'b0;
    cyc("br_reeval1", F_ID);
    RST = 1'b0;
    cyc("rand_sync", 11'b0, NO_ERR);
    m_wait = 0; m_err = 0; m_wn = 0; m_fl = 0;
    for (int i = 0; i < 3000; i++) begin
      v.rst = $urandom_range(0, 99) != 0;
      v.a1_id = $urandom_range(0, 4) == 0 ? 4'd15 : 4'($urandom_range(0, 3));
      v.a2_id = 4'($urandom_range(0, 3));
      v.a1_ex = $urandom_range(0, 4) == 0 ? 4'd15 : 4'($urandom_range(0, 3));
      v.a2_ex = 4'($urandom_range(0, 3));
      v.a3_ex = $urandom_range(0, 4) == 0 ? 4'd15 : 4'($urandom_range(0, 3));
      v.a3_mem = $urandom_range(0, 4) == 0 ? 4'd15 : 4'($urandom_range(0, 3));
      v.a3_wb = 4'($urandom_range(0, 3));
      v.we_ex = 1'($urandom); v.wbs_ex = 1'($urandom);
      v.we_mem = 1'($urandom); v.we_wb = 1'($urandom);
      v.br = $urandom_range(0, 5) == 0;
      v.req = $urandom_range(0, 3) == 0;
      v.rdy = $urandom_range(0, 2) != 0;
      apply(v);
      #1 check("random", model(v, m_wait, m_wn, m_fl, m_err), 11'h7FF);
      if (!v.rst) begin
        m_wait = 0; m_fl = 0; m_err = 0;
      end else if (m_wait) begin
        if (!v.rdy && m_wn == TO) m_err = 1;
        if (v.rdy || m_wn == TO) m_wait = 0;
        else m_wn++;
      end else if (v.req && !v.rdy) begin
        m_wait = 1; m_wn = 1; m_fl = 0;
      end else if (m_fl > 0) m_fl--;
      else if (v.br) m_fl = FC - 1;
      @(posedge CLK);
      #1;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
